svo_patgen: RTL and testbench
=============================

# svo_patgen

Parametrised, runtime-selectable test-pattern source for the SVO video pipeline. It generates one full frame of pixels per pass as an AXI-stream with start-of-frame and end-of-line markers, and feeds the SVO encoder or any downstream stream stage. It extends the fixed test card with:
- runtime pattern modes;
- configurable cell size and colour depth;
- a line marker;
- optional per-frame horizontal scrolling.

## Interface
Parameters:
- `HOR_PIXELS`, default 640: active pixels per line, ≥ 16.
- `VER_PIXELS`, default 480: active lines per frame, ≥ 2.
- `BPC`, default 8: bits per colour channel; pixel width is 3*BPC.
- `CELL_LOG2`, default 5: log2 of the square cell edge in pixels, 2..7.

Ports:
- `clk`, in, 1: the single clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `mode`, in, 3: pattern select, sampled once per frame.
- `solid_color`, in, 3*BPC: `{b,g,r}` colour for mode 0.
- `out_axis_tvalid`, out, 1: pixel valid.
- `out_axis_tready`, in, 1: downstream ready.
- `out_axis_tdata`, out, 3*BPC: pixel `{b,g,r}`.
- `out_axis_tuser`, out, 1: start of frame, high on pixel (0,0) only.
- `out_axis_tlast`, out, 1: end of line, high on x = HOR_PIXELS-1.

## Operation
- Counters:
  - `hcursor` runs 0..HOR_PIXELS-1; `vcursor` runs 0..VER_PIXELS-1.
  - Both wrap to 0 after the last pixel of the frame.
- Pattern x coordinate `px = (hcursor + scroll) mod HOR_PIXELS`; `scroll` is 0 unless scrolling is compiled in.
- Cell indices: `cx = px >> CELL_LOG2`, `cy = vcursor >> CELL_LOG2`.
- `mode_q` is loaded from `mode` when pixel (0,0) is computed. A `mode` change mid-frame has no effect until the next frame.
- Modes:
  - 0, solid: `solid_color` every pixel.
  - 1, colour bars: 8 bars of width `W = HOR_PIXELS/8` (integer division). Bar index is `min(px/W, 7)`. Order: white, yellow, cyan, green, magenta, red, blue, black. Full scale = all-ones BPC.
  - 2, grid: white where `px[CELL_LOG2-1:0]==0` or `vcursor[CELL_LOG2-1:0]==0`, and on the last column and last line; black elsewhere.
  - 3, checkerboard: white if `cx[0]^cy[0]`, else black.
  - 4, gradient: r = g = b = `px[BPC-1:0]`, wrapping every 2^BPC pixels.
  - 5, noise: xorshift32 state, seeded to 32'h075BCD15 at pixel (0,0). Advanced (`^<<13`, `^>>17`, `^<<5`) once per generated pixel. tdata = state[3*BPC-1:0]; for BPC > 10 the state is zero-extended in the upper bits.
  - 6 and 7: black.
- Stream:
  - tuser = (hcursor==0 && vcursor==0).
  - tlast = (hcursor==HOR_PIXELS-1).
  - No gaps are inserted; tvalid stays high after the first cycle.

## Timing
- Reset (asynchronous assert, synchronous-release use):
  - tvalid = 0, tdata = 0, tuser = 0, tlast = 0.
  - Cursors = 0, scroll = 0, `mode_q` = 0, noise state = seed.
- First cycle after `resetn` deasserts:
  - Pixel (0,0) is registered.
  - tvalid rises on the following edge, 1 cycle latency.
- Advance rule:
  - A new pixel is registered when `!tvalid || tready`.
  - While tvalid && !tready, tdata, tuser and tlast hold stable; cursors and noise state do not advance.
- Throughput: 1 pixel/clock with tready held high.
- Frame wrap: the cycle that accepts (HOR-1,VER-1) registers (0,0) with tuser = 1 and reloads `mode_q`.
- Reset mid-frame: output drops immediately. The stream restarts at pixel (0,0) with tuser; no partial frame resumes.
- Simultaneous `mode` change and frame wrap: the value present on that wrap cycle is the one captured.

## Configuration
- `SVO_PATGEN_SCROLL_EN` defined:
  - `scroll` increments by 1 mod HOR_PIXELS on each frame wrap.
  - Modes 1–4 drift left by one pixel per frame.
  - Modes 0 and 5 are unaffected.
- `SVO_PATGEN_SCROLL_EN` undefined: `scroll` is constant 0 and no register is built.

## Test plan
- Mode 0, `solid_color`=24'h123456, BPC=8, 640x480, tready=1: 307200 beats all 24'h123456. tuser only on beat 0; tlast on every 640th beat.
- Mode 1, 640x480: px 79 = 24'hFFFFFF, px 80 = yellow 24'h00FFFF, px 639 = 24'h000000. With HOR_PIXELS=650 (W=81), pixels 567..649 = black bar.
- Mode 3, CELL_LOG2=5: (31,0) white? No → black; (32,0) white; (32,32) black. Mode 2: (0,5) white, (5,5) black, (639,5) white.
- Backpressure: random tready at 30% high. tdata/tuser/tlast stable whenever tvalid && !tready. The accepted sequence is identical to the tready=1 run.
- Mode switch 0→4 at line 100: the rest of the frame stays solid; the next frame starts gradient, tdata at px 300 = 24'h2C2C2C. Reset asserted at line 200: tvalid = 0 same cycle; after release, the first beat has tuser = 1.
- With `SVO_PATGEN_SCROLL_EN`, mode 4: frame n pixel 0 = n mod 256 grey (n < 640). Without the macro every frame is identical.

Source files
------------

// File: rtl/svo_patgen.sv
// svo_patgen: runtime-selectable AXI-stream test-pattern source (one frame per pass).
// Define SVO_PATGEN_SCROLL_EN to build the per-frame horizontal scroll.
module svo_patgen #(
   parameter int unsigned HOR_PIXELS = 640,
   parameter int unsigned VER_PIXELS = 480,
   parameter int unsigned BPC        = 8,
   parameter int unsigned CELL_LOG2  = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [2:0]       mode,
   input  logic [3*BPC-1:0] solid_color,
   output logic             out_axis_tvalid,
   input  logic             out_axis_tready,
   output logic [3*BPC-1:0] out_axis_tdata,
   output logic             out_axis_tuser,
   output logic             out_axis_tlast
);
   localparam int unsigned HW        = $clog2(HOR_PIXELS);
   localparam int unsigned VW        = $clog2(VER_PIXELS);
   localparam int unsigned PW        = 3 * BPC;
   localparam int unsigned BAR_W     = HOR_PIXELS / 8;
   localparam int unsigned CELL_MASK = (1 << CELL_LOG2) - 1;
   localparam logic [31:0]   NOISE_SEED = 32'h075BCD15;
   localparam logic [HW-1:0] H_LAST     = HW'(HOR_PIXELS - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(VER_PIXELS - 1);
   localparam logic [HW:0]   H_MOD      = (HW+1)'(HOR_PIXELS);

   logic [HW-1:0] hcursor;
   logic [VW-1:0] vcursor;
   logic [HW-1:0] scroll;
   logic [2:0]    mode_q;
   logic [31:0]   noise_q;

   logic          advance_c, at_origin_c, last_col_c, last_row_c;
   logic [HW:0]   px_sum_c;
   logic [HW-1:0] px_c;
   logic [31:0]   px32_c, vc32_c, noise_cur_c;
   logic [2:0]    eff_mode_c, bar_c, bar_rgb_c;
   logic          grid_c, checker_c;
   logic [BPC-1:0] grey_c;
   logic [PW-1:0] noise_pix_c, pix_c;

   function automatic logic [31:0] xorshift(input logic [31:0] s);
      logic [31:0] t;
      t = s ^ (s << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   assign advance_c   = !out_axis_tvalid || out_axis_tready;
   assign last_col_c  = (hcursor == H_LAST);
   assign last_row_c  = (vcursor == V_LAST);
   assign at_origin_c = (hcursor == '0) && (vcursor == '0);
   // The origin pixel already uses the newly sampled mode and a fresh noise seed
   assign eff_mode_c  = at_origin_c ? mode : mode_q;
   assign noise_cur_c = at_origin_c ? NOISE_SEED : noise_q;

`ifdef SVO_PATGEN_SCROLL_EN
   // Scroll offset steps once per completed frame
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scroll <= '0;
      end else if (advance_c && last_col_c && last_row_c) begin
         scroll <= (scroll == H_LAST) ? '0 : scroll + HW'(1);
      end
   end
`else
   assign scroll = '0;
`endif

   assign px_sum_c = {1'b0, hcursor} + {1'b0, scroll};
   assign px_c     = (px_sum_c >= H_MOD) ? HW'(px_sum_c - H_MOD) : HW'(px_sum_c);
   assign px32_c   = 32'(px_c);
   assign vc32_c   = 32'(vcursor);

   assign bar_c     = ((px32_c / BAR_W) > 32'd7) ? 3'd7 : 3'(px32_c / BAR_W);
   assign grid_c    = ((px32_c & CELL_MASK) == 32'd0) || ((vc32_c & CELL_MASK) == 32'd0) ||
                      (px_c == H_LAST) || last_row_c;
   assign checker_c = px32_c[CELL_LOG2] ^ vc32_c[CELL_LOG2];
   assign grey_c    = BPC'(px_c);

   // Bar colours as {b,g,r} enables: white yellow cyan green magenta red blue black
   always_comb begin
      bar_rgb_c = 3'b000;
      case (bar_c)
         3'd0:    bar_rgb_c = 3'b111;
         3'd1:    bar_rgb_c = 3'b011;
         3'd2:    bar_rgb_c = 3'b110;
         3'd3:    bar_rgb_c = 3'b010;
         3'd4:    bar_rgb_c = 3'b101;
         3'd5:    bar_rgb_c = 3'b001;
         3'd6:    bar_rgb_c = 3'b100;
         default: bar_rgb_c = 3'b000;
      endcase
   end

   generate
      if (PW <= 32) begin : g_noise_trunc
         assign noise_pix_c = noise_cur_c[PW-1:0];
      end else begin : g_noise_ext
         assign noise_pix_c = {{(PW-32){1'b0}}, noise_cur_c};
      end
   endgenerate

   always_comb begin
      pix_c = '0;
      case (eff_mode_c)
         3'd0:    pix_c = solid_color;
         3'd1:    pix_c = {{BPC{bar_rgb_c[2]}}, {BPC{bar_rgb_c[1]}}, {BPC{bar_rgb_c[0]}}};
         3'd2:    pix_c = {PW{grid_c}};
         3'd3:    pix_c = {PW{checker_c}};
         3'd4:    pix_c = {3{grey_c}};
         3'd5:    pix_c = noise_pix_c;
         default: pix_c = '0;
      endcase
   end

   // Output register and raster cursors; everything holds while the sink stalls
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_axis_tvalid <= 1'b0;
         out_axis_tdata  <= '0;
         out_axis_tuser  <= 1'b0;
         out_axis_tlast  <= 1'b0;
         hcursor         <= '0;
         vcursor         <= '0;
         mode_q          <= 3'd0;
         noise_q         <= NOISE_SEED;
      end else if (advance_c) begin
         out_axis_tvalid <= 1'b1;
         out_axis_tdata  <= pix_c;
         out_axis_tuser  <= at_origin_c;
         out_axis_tlast  <= last_col_c;
         noise_q         <= xorshift(noise_cur_c);
         if (at_origin_c) begin
            mode_q <= mode;
         end
         if (last_col_c) begin
            hcursor <= '0;
            vcursor <= last_row_c ? '0 : vcursor + VW'(1);
         end else begin
            hcursor <= hcursor + HW'(1);
         end
      end
   end
endmodule

// File: tb/tb_svo_patgen.sv
// Bench for svo_patgen: frame scoreboard, spot-check vector table, backpressure and reset cases.
module tb_svo_patgen;
   localparam int HOR = 42;
   localparam int VER = 6;
   localparam int BPC = 8;
   localparam int CELL_LOG2 = 2;
   localparam int CELL = 4;
   localparam int PW = 24;
   localparam int NV = 26;
   localparam logic [31:0] SEED = 32'h075BCD15;
`ifdef SVO_PATGEN_SCROLL_EN
   localparam int SCR1 = 1;
`else
   localparam int SCR1 = 0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic [2:0]    mode = 3'd0;
   logic [PW-1:0] solid_color = 24'h123456;
   logic          tvalid, tready = 1'b1, tuser, tlast;
   logic [PW-1:0] tdata;

   svo_patgen #(.HOR_PIXELS(HOR), .VER_PIXELS(VER), .BPC(BPC), .CELL_LOG2(CELL_LOG2)) dut (
      .clk(clk), .resetn(resetn), .mode(mode), .solid_color(solid_color),
      .out_axis_tvalid(tvalid), .out_axis_tready(tready), .out_axis_tdata(tdata),
      .out_axis_tuser(tuser), .out_axis_tlast(tlast));

   always #5 clk = ~clk;

   typedef struct {
      logic          tuser;
      logic          tlast;
      logic [PW-1:0] tdata;
      int            x;
      int            y;
   } beat_t;

   typedef struct {
      logic [2:0]    m;
      int            x;
      int            y;
      logic [PW-1:0] exp;
   } vec_t;

   beat_t         sb[$];
   beat_t         e;
   vec_t          vt[NV];
   logic [PW-1:0] fbuf[HOR*VER];
   logic [PW-1:0] bars[8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                             24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
   int            checks = 0, failures = 0, beats = 0, frame_no = 0;
   bit            bp_en = 0, stalled = 0;
   logic [PW+2:0] held;

   function automatic logic [31:0] xs(input logic [31:0] s);
      logic [31:0] t;
      t = s ^ (s << 13);
      t = t ^ (t >> 17);
      return t ^ (t << 5);
   endfunction

   function automatic logic [PW-1:0] exp_pixel(input int m, input int x, input int y,
                                                input int scr, input logic [31:0] ns);
      int px, idx;
      px = (x + scr) % HOR;
      case (m)
         0: return solid_color;
         1: begin
            idx = px / (HOR / 8);
            if (idx > 7) idx = 7;
            return bars[idx];
         end
         2: return ((px % CELL == 0) || (y % CELL == 0) || px == HOR-1 || y == VER-1) ? 24'hFFFFFF : 24'h0;
         3: return (((px / CELL) + (y / CELL)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
         4: return {3{8'(px % 256)}};
         5: return ns[PW-1:0];
         default: return 24'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_frame(input int m);
      beat_t b;
      logic [31:0] ns;
      int scr;
      scr = (frame_no * SCR1) % HOR;
      ns = SEED;
      for (int y = 0; y < VER; y++) begin
         for (int x = 0; x < HOR; x++) begin
            b.tdata = exp_pixel(m, x, y, scr, ns);
            b.tuser = (x == 0 && y == 0);
            b.tlast = (x == HOR-1);
            b.x = x;
            b.y = y;
            sb.push_back(b);
            ns = xs(ns);
         end
      end
      frame_no++;
   endtask

   task automatic do_reset(input int m);
      resetn = 1'b0;
      sb.delete();
      #1;
      chk("rst_tvalid", 32'(tvalid), 0);
      chk("rst_tdata", 32'(tdata), 0);
      chk("rst_tuser", 32'(tuser), 0);
      chk("rst_tlast", 32'(tlast), 0);
      mode = 3'(m);
      frame_no = 0;
      beats = 0;
      push_frame(m);
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      chk("latency_tvalid_low", 32'(tvalid), 0);
      @(negedge clk);
      chk("latency_tvalid_high", 32'(tvalid), 1);
      chk("first_tuser", 32'(tuser), 1);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 0);
   endtask

   task automatic wait_beats(input int target, input int budget);
      int n = 0;
      while (beats < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("beat_timeout", 32'(beats >= target), 1);
   endtask

   // Sink-ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1 tready = bp_en ? ($urandom_range(99, 0) < 30) : 1'b1;
      end
   end

   // Monitor: hold-stability while stalled, scoreboard pop on each accepted beat
   always @(negedge clk) begin
      if (!resetn) begin
         stalled = 0;
      end else begin
         if (stalled) begin
            checks++;
            if ({tvalid, tuser, tlast, tdata} !== held) begin
               failures++;
               $display("FAIL hold_stable actual=%h required=%h", {tvalid, tuser, tlast, tdata}, held);
            end
         end
         if (tvalid && tready && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({tuser, tlast, tdata} !== {e.tuser, e.tlast, e.tdata}) begin
               failures++;
               $display("FAIL beat(%0d,%0d) actual=%h required=%h", e.x, e.y,
                        {tuser, tlast, tdata}, {e.tuser, e.tlast, e.tdata});
            end
            fbuf[e.y*HOR + e.x] = tdata;
            beats++;
         end
         stalled = tvalid && !tready;
         held = {tvalid, tuser, tlast, tdata};
      end
   end

   initial begin
      vt[0]  = '{3'd0, 0, 0, 24'h123456};
      vt[1]  = '{3'd0, 41, 5, 24'h123456};
      vt[2]  = '{3'd1, 4, 0, 24'hFFFFFF};
      vt[3]  = '{3'd1, 5, 0, 24'h00FFFF};
      vt[4]  = '{3'd1, 10, 2, 24'hFFFF00};
      vt[5]  = '{3'd1, 20, 1, 24'hFF00FF};
      vt[6]  = '{3'd1, 29, 1, 24'h0000FF};
      vt[7]  = '{3'd1, 34, 0, 24'hFF0000};
      vt[8]  = '{3'd1, 35, 0, 24'h000000};
      vt[9]  = '{3'd1, 41, 3, 24'h000000};
      vt[10] = '{3'd2, 0, 1, 24'hFFFFFF};
      vt[11] = '{3'd2, 1, 1, 24'h000000};
      vt[12] = '{3'd2, 41, 1, 24'hFFFFFF};
      vt[13] = '{3'd2, 1, 5, 24'hFFFFFF};
      vt[14] = '{3'd2, 4, 1, 24'hFFFFFF};
      vt[15] = '{3'd2, 1, 4, 24'hFFFFFF};
      vt[16] = '{3'd2, 3, 3, 24'h000000};
      vt[17] = '{3'd3, 3, 0, 24'h000000};
      vt[18] = '{3'd3, 4, 0, 24'hFFFFFF};
      vt[19] = '{3'd3, 4, 4, 24'h000000};
      vt[20] = '{3'd3, 0, 4, 24'hFFFFFF};
      vt[21] = '{3'd4, 41, 2, 24'h292929};
      vt[22] = '{3'd4, 7, 5, 24'h070707};
      vt[23] = '{3'd5, 0, 0, 24'h5BCD15};
      vt[24] = '{3'd6, 20, 3, 24'h000000};
      vt[25] = '{3'd7, 20, 3, 24'h000000};

      #2;
      // Every mode, one frame after reset, full-rate sink
      for (int m = 0; m < 8; m++) begin
         do_reset(m);
         wait_drain(HOR*VER + 50);
         for (int i = 0; i < NV; i++) begin
            if (vt[i].m == 3'(m))
               chk($sformatf("vec%0d_m%0d_(%0d,%0d)", i, m, vt[i].x, vt[i].y),
                   32'(fbuf[vt[i].y*HOR + vt[i].x]), 32'(vt[i].exp));
         end
      end

      // Random backpressure over two frames of noise, then two of gradient
      bp_en = 1;
      do_reset(5);
      push_frame(5);
      wait_drain(8*HOR*VER);
      do_reset(4);
      push_frame(4);
      wait_drain(8*HOR*VER);
      bp_en = 0;

      // Mid-frame mode change only takes effect on the next frame
      do_reset(0);
      push_frame(4);
      wait_beats(3*HOR, 10*HOR);
      mode = 3'd4;
      wait_drain(3*HOR*VER);
      chk("switch_grad_px10", 32'(fbuf[5*HOR + 10]), 32'({3{8'(10 + SCR1)}}));

      // Reset in the middle of a frame restarts cleanly at the origin
      do_reset(2);
      wait_beats(2*HOR + 5, 10*HOR);
      do_reset(2);
      wait_drain(HOR*VER + 50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
